// File: rtl/key_press_pulse.sv
// key_press_pulse: conditions a raw active-low push-button pin into clean
// single-cycle press/release pulses and a debounced held level.
// The pin is brought into the clk domain by a two-flop synchronizer. A
// stability counter then accepts a level change only after DEBOUNCE_CYCLES
// consecutive mismatching samples.
// The release pulse port is named release_pulse because "release" is a
// reserved word in SystemVerilog.
module key_press_pulse #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press,
  output logic release_pulse,
  output logic held
);

  // The held bit is the state MSB, so held comes straight from a flop.
  typedef enum logic [1:0] {
    UP_STABLE   = 2'b00,
    UP_COUNT    = 2'b01,
    DOWN_STABLE = 2'b10,
    DOWN_COUNT  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             raw;
  logic             done;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             press_next;
  logic             release_next;

  assign raw  = ~s2;
  assign done = (cnt == LAST);
  assign held = state[1];

  // Two-flop synchronizer. Only s1 may go metastable, and only s2 reads it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= key_n;
      s2 <= s1;
    end
  end

  // Debounce state, stability counter and registered edge pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= UP_STABLE;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      press         <= press_next;
      release_pulse <= release_next;
    end
  end

  // Next state: a sample matching the held level clears the count. A full
  // run of mismatching samples flips the level and fires one pulse.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state)
      UP_STABLE, UP_COUNT: begin
        if (!raw) begin
          state_next = UP_STABLE;
          cnt_next   = '0;
        end else if (done) begin
          state_next = DOWN_STABLE;
          cnt_next   = '0;
          press_next = 1'b1;
        end else begin
          state_next = UP_COUNT;
          cnt_next   = cnt + CNT_W'(1);
        end
      end
      DOWN_STABLE, DOWN_COUNT: begin
        if (raw) begin
          state_next = DOWN_STABLE;
          cnt_next   = '0;
        end else if (done) begin
          state_next   = UP_STABLE;
          cnt_next     = '0;
          release_next = 1'b1;
        end else begin
          state_next = DOWN_COUNT;
          cnt_next   = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = UP_STABLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_press_pulse.sv
// Testbench for key_press_pulse with DEBOUNCE_CYCLES = 4. A behavioural
// model pushes the expected {press, release, held} for every clock into a
// scoreboard queue. The value is popped and compared just after the edge.
module tb_key_press_pulse;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  logic key_n;
  logic press;
  logic release_pulse;
  logic held;

  always #5 clk = ~clk;

  key_press_pulse #(.DEBOUNCE_CYCLES(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .key_n         (key_n),
    .press         (press),
    .release_pulse (release_pulse),
    .held          (held)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [2:0] exp_q[$];

  // Model state: synchronizer copy, accepted level and the last N raw samples.
  logic m_s1;
  logic m_s2;
  logic m_held;
  logic hist[N];
  int   nvalid;

  int cyc          = 0;
  int press_cnt    = 0;
  int release_cnt  = 0;
  int last_press   = -1;
  int last_release = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_s1   = 1'b1;
    m_s2   = 1'b1;
    m_held = 1'b0;
    nvalid = 0;
    for (int i = 0; i < N; i++) hist[i] = 1'b0;
  endtask

  // Drive one clock of stimulus at the negedge. Predict the outputs after the
  // next rising edge, then check them 1 time unit after that edge.
  task automatic cycle(input logic kn, input logic rn);
    logic       raw;
    logic       flip;
    logic       old_held;
    logic [2:0] e;
    logic [2:0] got;
    key_n = kn;
    reset = rn;
    if (!rn) begin
      model_reset();
      e = 3'b000;
      #1;
      got = {press, release_pulse, held};
      chk("async_reset", got, 3'b000);
    end else begin
      raw      = ~m_s2;
      old_held = m_held;
      for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = raw;
      if (nvalid < N) nvalid++;
      flip = (nvalid == N);
      for (int i = 0; i < N; i++) if (hist[i] == old_held) flip = 1'b0;
      if (flip) begin
        m_held = ~old_held;
        nvalid = 0;
      end
      e    = {flip & ~old_held, flip & old_held, m_held};
      m_s2 = m_s1;
      m_s1 = kn;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    got = {press, release_pulse, held};
    chk("outputs", got, exp_q.pop_front());
    chk("mutex", press & release_pulse, 1'b0);
    if (press) begin
      press_cnt++;
      last_press = cyc;
    end
    if (release_pulse) begin
      release_cnt++;
      last_release = cyc;
    end
    @(negedge clk);
  endtask

  int pc;
  int rc;
  int c0;

  initial begin
    key_n = 1'b1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset held with the pin toggling, then released with the pin idle.
    for (int i = 0; i < 6; i++) cycle(logic'(i[0]), 1'b0);
    repeat (10) cycle(1'b1, 1'b1);
    chk("t1_press_cnt", press_cnt, 0);
    chk("t1_release_cnt", release_cnt, 0);
    chk("t1_held", held, 1'b0);

    // Clean push.
    pc = press_cnt;
    c0 = cyc + 1;
    repeat (20) cycle(1'b0, 1'b1);
    chk("t2_press_cnt", press_cnt - pc, 1);
    chk("t2_press_latency", last_press - c0, 5);
    chk("t2_held", held, 1'b1);

    // Release, then push again.
    rc = release_cnt;
    c0 = cyc + 1;
    repeat (10) cycle(1'b1, 1'b1);
    chk("t5_release_cnt", release_cnt - rc, 1);
    chk("t5_release_latency", last_release - c0, 5);
    chk("t5_held_up", held, 1'b0);
    pc = press_cnt;
    c0 = cyc + 1;
    repeat (10) cycle(1'b0, 1'b1);
    chk("t5_press_cnt", press_cnt - pc, 1);
    chk("t5_press_latency", last_press - c0, 5);
    repeat (10) cycle(1'b1, 1'b1);

    // Bouncing push.
    pc = press_cnt;
    repeat (3) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    repeat (2) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    c0 = cyc + 1;
    repeat (15) cycle(1'b0, 1'b1);
    chk("t3_press_cnt", press_cnt - pc, 1);
    chk("t3_press_latency", last_press - c0, 5);
    repeat (10) cycle(1'b1, 1'b1);

    // Short glitch.
    pc = press_cnt;
    rc = release_cnt;
    repeat (3) cycle(1'b0, 1'b1);
    repeat (10) cycle(1'b1, 1'b1);
    chk("t4_press_cnt", press_cnt - pc, 0);
    chk("t4_release_cnt", release_cnt - rc, 0);
    chk("t4_held", held, 1'b0);

    // Reset in mid-count, with the button held through the reset.
    pc = press_cnt;
    repeat (2) cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);
    chk("t6_no_press_in_reset", press_cnt - pc, 0);
    c0 = cyc + 1;
    repeat (12) cycle(1'b0, 1'b1);
    chk("t6_press_cnt", press_cnt - pc, 1);
    chk("t6_press_latency", last_press - c0, 5);
    chk("t6_held", held, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
